// File: rtl/jk_excitation_driver.sv
// jk_excitation_driver
//
// Turns a stream of target register words into per-bit J/K excitation for a
// bank of external JK flip-flops. This is the inverse of the flip-flop: given
// the bank's current Q (S) and the wanted next Q (T), it drives
//   j = T & ~S,  k = ~T & S
// Bits that do not change get j=k=0, and the toggle code 11 is never emitted.
// Targets arrive through a small valid/ready FIFO. Each word takes a DRIVE
// cycle followed by a CHECK cycle, so j/k are never non-zero on two
// consecutive cycles.
//
// Optional feature macro: JK_FB_CHECK_EN
//   When it is defined, the bank's Q feedback is compared against the model at
//   the end of CHECK. A mismatch pulses err, bumps a saturating err_count and
//   resyncs the model to the real bank value.
//
// Ports
//   clock      in          rising-edge clock
//   reset      in          synchronous active-low reset
//   in_valid   in          target word offered
//   in_ready   out         FIFO not full
//   in_data    in  [W]     target Q value
//   j, k       out [W]     registered excitation
//   state      out [W]     model of the bank's Q
//   busy       out         FSM active or FIFO not empty
//   q_fb       in  [W]     bank Q feedback           (JK_FB_CHECK_EN only)
//   err        out         one-cycle mismatch pulse  (JK_FB_CHECK_EN only)
//   err_count  out [8]     saturating mismatch count (JK_FB_CHECK_EN only)
//
// FSM
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | j=k=0, waiting for a target; pops as soon as FIFO non-empty
//   ST_DRIVE | j/k held for exactly one cycle; state <= target on exit
//   ST_CHECK | j=k=0 hold; optional feedback compare; may pop the next word

module jk_excitation_driver #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic [WIDTH-1:0] state,
    output logic             busy
`ifdef JK_FB_CHECK_EN
    ,
    input  logic [WIDTH-1:0] q_fb,
    output logic             err,
    output logic [7:0]       err_count
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRIVE = 2'd1;
    localparam logic [1:0] ST_CHECK = 2'd2;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic [1:0]       fsm;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] head;
    logic [WIDTH-1:0] base;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign in_ready = !full;
    assign push     = in_valid && !full;
    assign pop      = !empty && ((fsm == ST_IDLE) || (fsm == ST_CHECK));
    assign head     = mem[rd_ptr[AW-1:0]];
    assign busy     = (fsm != ST_IDLE) || !empty;

`ifdef JK_FB_CHECK_EN
    logic resync;

    // The compare only matters on the CHECK-exit edge. When it fails, the
    // excitation popped on that same edge must already use the real bank value.
    assign resync = (fsm == ST_CHECK) && (q_fb != state);
    assign base   = resync ? q_fb : state;
`else
    assign base   = state;
`endif

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= in_data;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fsm    <= ST_IDLE;
            j      <= '0;
            k      <= '0;
            target <= '0;
            state  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end

            j <= '0;
            k <= '0;

            case (fsm)
                ST_IDLE, ST_CHECK: begin
                    if (pop) begin
                        j      <= head & ~base;
                        k      <= ~head & base;
                        target <= head;
                        fsm    <= ST_DRIVE;
                    end else begin
                        fsm    <= ST_IDLE;
                    end
                end
                ST_DRIVE: begin
                    state <= target;
                    fsm   <= ST_CHECK;
                end
                default: begin
                    fsm <= ST_IDLE;
                end
            endcase

`ifdef JK_FB_CHECK_EN
            if (resync) begin
                state <= q_fb;
            end
`endif
        end
    end

`ifdef JK_FB_CHECK_EN
    always_ff @(posedge clock) begin
        if (!reset) begin
            err       <= 1'b0;
            err_count <= 8'd0;
        end else begin
            err <= resync;
            if (resync && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end
        end
    end
`endif

endmodule

// File: doc/jk_excitation_driver.md
# jk_excitation_driver

Parameterised driver that turns a stream of target register words into per-bit J/K excitation for a bank of external `jk_flip_flop` instances. It implements the inverse of the flip-flop: the flip-flop maps (J,K,Q) to Q+, and this block maps (Q,Q+) to (J,K). Target words enter through a valid/ready FIFO. The block tracks the flip-flop bank's state and, optionally, checks the bank's Q feedback against the expected state. It sits between a sequencing controller and a JK register bank, and serves as the stimulus side of flip-flop bring-up and regression.

## Interface
Parameters:
- `WIDTH`, 4: number of J/K bit pairs driven.
- `DEPTH`, 4: target FIFO entries; must be a power of two, at least 2.

Ports:
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-low reset.
- `in_valid` in 1: target word offered.
- `in_ready` out 1: FIFO can accept a word; equals !full.
- `in_data` in WIDTH: target Q value.
- `j` out WIDTH: registered J excitation.
- `k` out WIDTH: registered K excitation.
- `state` out WIDTH: block's model of the bank's Q.
- `busy` out 1: FSM not IDLE, or FIFO not empty.
- `q_fb` in WIDTH: bank Q feedback. Present only with `JK_FB_CHECK_EN`.
- `err` out 1: one-cycle mismatch pulse. Present only with `JK_FB_CHECK_EN`.
- `err_count` out 8: saturating mismatch count. Present only with `JK_FB_CHECK_EN`.

## Operation
- FIFO
  - Push on `in_valid && in_ready`.
  - Pop only by the FSM.
  - Read/write pointers are log2(DEPTH)+1 bits and wrap naturally.
  - A push while full is impossible, because `in_ready` is low.
  - A simultaneous push and pop when not full leaves the occupancy unchanged.
- Excitation for popped target T against `state` S, with minimal toggles and don't-cares resolved to 0:
  - `j = T & ~S`
  - `k = ~T & S`
  - Bits that do not change get j=k=0. The toggle code 11 is never emitted.
- FSM states: IDLE, DRIVE, CHECK.
  - IDLE: j=k=0. If the FIFO is non-empty, pop T, register j/k, and go to DRIVE.
  - DRIVE: j/k are held for exactly one cycle. At the next edge, j=k=0, `state` <= T, and go to CHECK.
  - CHECK: j=k=0. At the next edge, if the FIFO is non-empty, pop, register new j/k, and go to DRIVE. Otherwise go to IDLE.
- Feedback check (macro enabled), at the CHECK-exit edge:
  - A mismatch exists if `q_fb != state`.
  - On mismatch: `err`=1 for one cycle, `err_count` increments and saturates at 255, and `state` <= `q_fb` (resync).
  - The next excitation is therefore computed from the actual bank value.
- Reset (when `reset`=0 at an edge, including mid-DRIVE or mid-CHECK):
  - FSM goes to IDLE and the FIFO is emptied; in-flight and queued words are dropped.
  - j=0, k=0, state=0, err=0, err_count=0, busy=0.
  - `in_ready`=1 once reset is released.
  - The external bank is reset in the same cycle, so it starts at Q=0.

## Timing
- The word accepted at edge e0 into an empty FIFO with the FSM in IDLE proceeds as follows:
  - e1: pop, and j/k become valid.
  - e2: the bank samples j/k, j/k return to 0, and `state` = T.
  - During e2..e3: `q_fb` must equal T.
  - e3: the compare takes effect and `err` is visible after e3.
- Latency from accept to j/k valid is 1 cycle.
- Sustained throughput is one word per 2 cycles (DRIVE and CHECK alternate).
- j/k are non-zero for at most one cycle per word and are never non-zero in two consecutive cycles.
- `in_ready` deasserts the cycle after the push that fills the FIFO. It reasserts the cycle after the next pop.

## Configuration
- `JK_FB_CHECK_EN` defined:
  - `q_fb`, `err` and `err_count` exist.
  - CHECK performs the compare and resync.
- `JK_FB_CHECK_EN` undefined:
  - Those three ports and the compare logic are removed.
  - CHECK remains a one-cycle hold with j=k=0, so timing and throughput are identical.
  - `state` always follows T.

## Test plan
WIDTH=4, DEPTH=4, with a `jk_flip_flop` bank wired to j/k and `q_fb`.
- Reset: hold `reset`=0 for 2 edges -> j=k=0000, state=0000, busy=0, err_count=0; after release, in_ready=1.
- From state 0000, push 1010 -> one cycle of j=1010, k=0000; then state=1010 and bank Q=1010, with err=0.
- Then push 0110 -> one cycle of j=0100, k=1000; then state=0110 and bank Q=0110.
- Hold `in_valid`=1 with words 1..8 every cycle -> in_ready drops when the FIFO is full; all 8 words are driven in order, 2 cycles apart, with none lost or duplicated.
- Force `q_fb`=0000 while target 1111 is in CHECK -> err=1 for one cycle, err_count=1, state=0000; the next target 1111 yields j=1111, k=0000.
- Assert `reset` during DRIVE with 3 words queued -> j=k=0000 after that edge and the FIFO is empty; after release, no queued word is ever driven.
